// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline constants: FSM encoding, register-zero index and opcode values
// used by the hazard/stall control slice.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } haz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds either ID source.
import hazard_stall_ctrl_pkg::*;

module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd_ind,
    input  logic [4:0] id_rs1_ind,
    input  logic [4:0] id_rs2_ind,
    output logic       load_use
);

    assign load_use = ex_memread & (ex_rd_ind != REG_ZERO) &
                      ((ex_rd_ind == id_rs1_ind) | (ex_rd_ind == id_rs2_ind));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: branch flush, load-use stall, multi-cycle MDU hold
// and imem wait. Optional performance counters enabled by macro HAZ_PERF_CNT_EN.
import hazard_stall_ctrl_pkg::*;

module hazard_stall_ctrl #(
    parameter int unsigned MDU_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_ind,
    input  logic [4:0]  id_rs2_ind,
    input  logic        id_mdu_op,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd_ind,
    input  logic        ex_branch_taken,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_flush,
    output logic        id_ex_bubble,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    // The issue cycle in RUN is the first stall cycle, so MDU_BUSY lasts
    // MDU_LATENCY-1 cycles (counter values MDU_LATENCY-2 down to 0).
    localparam logic [7:0] MDU_LOAD = 8'(MDU_LATENCY - 2);

    haz_state_e state_q, state_d;
    logic [7:0] mdu_cnt_q, mdu_cnt_d;
    logic       load_use;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd_ind  (ex_rd_ind),
        .id_rs1_ind (id_rs1_ind),
        .id_rs2_ind (id_rs2_ind),
        .load_use   (load_use)
    );

    always_comb begin
        state_d      = state_q;
        mdu_cnt_d    = mdu_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    if_flush     = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_mdu_op) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_d     = MDU_BUSY;
                    mdu_cnt_d   = MDU_LOAD;
                end else if (!imem_ready) begin
                    pc_write = 1'b0;
                    if_flush = 1'b1;
                end
            end
            MDU_BUSY: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                mdu_busy     = 1'b1;
                if (mdu_cnt_q == 8'd0) begin
                    state_d  = RUN;
                    mdu_done = 1'b1;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            mdu_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (if_flush && if_id_write && ex_branch_taken && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
